// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: execute-stage request/response bundle for the iterative multiply/divide unit.
//
//   valid_i   : execute-stage instruction is a mul/div op
//   op_i      : 0=MUL 1=DIV 2=DIVU 3=REM 4=REMU (5-7 decode as MUL)
//   word_i    : 32-bit word op, result sign-extended from bit 31
//   a_i, b_i  : operands (dividend/multiplicand, divisor/multiplier)
//   flush_i   : kill the in-flight op
//   hold_i    : downstream stall, pipeline not advancing
//   busy_o    : execute-stage stall request
//   done_o    : result_o valid
//   result_o  : result
//
// master drives the request side (pipeline / bench), slave is the unit itself.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 64
) ();
    logic            valid_i;
    logic [2:0]      op_i;
    logic            word_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            hold_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, op_i, word_i, a_i, b_i, flush_i, hold_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  valid_i, op_i, word_i, a_i, b_i, flush_i, hold_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide unit (RISC-V MUL, DIV, DIVU, REM,
// REMU plus 32-bit word variants). Stalls the execute stage while an op is in flight, holds the
// result in DONE while the pipeline is held, and drops work on flush.
//
// Ports:
//   clk     : clock
//   resetn  : asynchronous active-low reset
//   bus     : muldiv_unit_if.slave (valid_i/op_i/word_i/a_i/b_i/flush_i/hold_i in,
//             busy_o/done_o/result_o out)
//
// Optional build macro MULDIV_EARLY_OUT_EN: MUL finishes as soon as the remaining multiplier
// bits are zero (zero operands finish directly). Results are identical in both builds.
module muldiv_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic         clk,
    input  logic         resetn,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [2:0] OpMul  = 3'd0;
    localparam logic [2:0] OpDiv  = 3'd1;
    localparam logic [2:0] OpRem  = 3'd3;
    localparam logic [2:0] OpRemu = 3'd4;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int unsigned i = 32; i < XLEN; i++) r[i] = v[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int unsigned i = 32; i < XLEN; i++) r[i] = 1'b0;
        return r;
    endfunction

    // State. acc holds the product (MUL) or partial remainder (divide); opa holds the
    // multiplicand or the dividend/quotient shift register; opb the multiplier or divisor.
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  opa_q, opa_d;
    logic [XLEN-1:0]  opb_q, opb_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             is_mul_q, is_mul_d;
    logic             is_rem_q, is_rem_d;
    logic             word_q, word_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;

    // Request decode
    logic            op_mul, op_rem, op_signed;
    logic [XLEN-1:0] a_s, b_s, mag_a, mag_b, min_n, spec_res;
    logic            sign_a, sign_b, div_zero, div_ovf, mul_zero;

    always_comb begin
        op_mul    = (bus.op_i == OpMul) || (bus.op_i > OpRemu);
        op_rem    = (bus.op_i == OpRem) || (bus.op_i == OpRemu);
        op_signed = (bus.op_i == OpDiv) || (bus.op_i == OpRem);
        a_s       = bus.word_i ? sext32(bus.a_i) : bus.a_i;
        b_s       = bus.word_i ? sext32(bus.b_i) : bus.b_i;
        sign_a    = op_signed & a_s[XLEN-1];
        sign_b    = op_signed & b_s[XLEN-1];
        mag_a     = sign_a ? -a_s : a_s;
        mag_b     = sign_b ? -b_s : b_s;
        if (bus.word_i) begin
            mag_a = zext32(mag_a);
            mag_b = zext32(mag_b);
        end
        min_n    = bus.word_i ? sext32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = !op_mul && (b_s == '0);
        div_ovf  = op_signed && (a_s == min_n) && (b_s == '1);
        if (div_zero) spec_res = op_rem ? a_s : '1;
        else          spec_res = op_rem ? '0 : a_s;
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_zero = op_mul && ((a_s == '0) || (b_s == '0));
`else
    assign mul_zero = 1'b0;
`endif

    // One iteration of the datapath and the result that would be committed after it
    logic [XLEN-1:0] acc_n, opa_n, opb_n, quo_fix, rem_fix, fin_res;
    logic [XLEN:0]   rem_sh, diff;
    logic            last_iter;

    always_comb begin
        rem_sh = {acc_q, opa_q[XLEN-1]};
        diff   = rem_sh - {1'b0, opb_q};
        if (is_mul_q) begin
            acc_n = acc_q + (opb_q[0] ? opa_q : '0);
            opa_n = opa_q << 1;
            opb_n = opb_q >> 1;
        end else begin
            // Restoring step: keep the subtraction only if it did not borrow
            acc_n = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            opa_n = {opa_q[XLEN-2:0], ~diff[XLEN]};
            opb_n = opb_q;
        end
        quo_fix = quo_neg_q ? -opa_n : opa_n;
        rem_fix = rem_neg_q ? -acc_n : acc_n;
        fin_res = is_mul_q ? acc_n : (is_rem_q ? rem_fix : quo_fix);
        if (word_q) fin_res = sext32(fin_res);
        last_iter = (cnt_q == CNT_W'(1));
`ifdef MULDIV_EARLY_OUT_EN
        if (is_mul_q && (opb_n == '0)) last_iter = 1'b1;
`endif
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        is_mul_d  = is_mul_q;
        is_rem_d  = is_rem_q;
        word_d    = word_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;

        if (bus.flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.valid_i) begin
                        is_mul_d  = op_mul;
                        is_rem_d  = op_rem;
                        word_d    = bus.word_i;
                        quo_neg_d = sign_a ^ sign_b;
                        rem_neg_d = sign_a;
                        acc_d     = '0;
                        if (op_mul) begin
                            opa_d = bus.word_i ? zext32(bus.a_i) : bus.a_i;
                            opb_d = bus.word_i ? zext32(bus.b_i) : bus.b_i;
                        end else begin
                            // Left-align the dividend so the next bit is always opa[XLEN-1]
                            opa_d = bus.word_i ? (mag_a << (XLEN - 32)) : mag_a;
                            opb_d = mag_b;
                        end
                        if (div_zero || div_ovf) begin
                            state_d  = StDone;
                            result_d = spec_res;
                            cnt_d    = '0;
                        end else if (mul_zero) begin
                            state_d  = StDone;
                            result_d = '0;
                            cnt_d    = '0;
                        end else begin
                            state_d = StBusy;
                            cnt_d   = bus.word_i ? CNT_W'(32) : CNT_W'(XLEN);
                        end
                    end
                end
                StBusy: begin
                    acc_d = acc_n;
                    opa_d = opa_n;
                    opb_d = opb_n;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (last_iter) begin
                        state_d  = StDone;
                        result_d = fin_res;
                        cnt_d    = '0;
                    end
                end
                StDone: begin
                    // valid_i is still the same instruction here; only hold_i matters
                    if (!bus.hold_i) state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            is_mul_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            word_q    <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            is_mul_q  <= is_mul_d;
            is_rem_q  <= is_rem_d;
            word_q    <= word_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    // Stall only for a live mul/div request; reset and flush force it low combinationally
    assign bus.busy_o   = resetn && bus.valid_i && !bus.flush_i &&
                          ((state_q == StIdle) || (state_q == StBusy));
    assign bus.done_o   = (state_q == StDone);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int unsigned XLEN = 64;
    localparam logic [63:0] MinVal = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic on the RISC-V rules
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] ua, ub, r;
        if (word) begin
            sa = {{32{a[31]}}, a[31:0]};
            sb = {{32{b[31]}}, b[31:0]};
            ua = {32'h0, a[31:0]};
            ub = {32'h0, b[31:0]};
        end else begin
            sa = a;
            sb = b;
            ua = a;
            ub = b;
        end
        if (op == 3'd1 || op == 3'd3) begin
            if (sb == 0) begin
                r = (op == 3'd3) ? sa : 64'hFFFF_FFFF_FFFF_FFFF;
            end else if (sb == -1) begin
                sq = -sa;
                r  = (op == 3'd3) ? 64'd0 : sq;
            end else begin
                sq = sa / sb;
                sr = sa % sb;
                r  = (op == 3'd3) ? sr : sq;
            end
        end else if (op == 3'd2 || op == 3'd4) begin
            if (ub == 0) r = (op == 3'd4) ? ua : 64'hFFFF_FFFF_FFFF_FFFF;
            else         r = (op == 3'd4) ? (ua % ub) : (ua / ub);
        end else begin
            r = ua * ub;
        end
        if (word) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    // Clock edges from the accept edge until done_o is first seen
    function automatic int ref_edges(input logic [2:0] op, input logic word,
                                     input logic [63:0] a, input logic [63:0] b);
        logic [63:0] am, bm;
        int n;
        int msb;
        bit ovf;
        n   = word ? 32 : 64;
        am  = word ? {32'h0, a[31:0]} : a;
        bm  = word ? {32'h0, b[31:0]} : b;
        msb = -1;
        for (int i = 0; i < 64; i++) if (bm[i]) msb = i;
        if (op == 3'd0 || op > 3'd4) begin
`ifdef MULDIV_EARLY_OUT_EN
            if (am == 0 || bm == 0) return 1;
            return msb + 2;
`else
            return n + 1;
`endif
        end
        if (bm == 0) return 1;
        ovf = word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                   : (a == MinVal && b == 64'hFFFF_FFFF_FFFF_FFFF);
        if ((op == 3'd1 || op == 3'd3) && ovf) return 1;
        return n + 1;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input int hold_cyc);
        logic [63:0] exp;
        int exp_e;
        int edges;
        bit gap;
        exp   = ref_result(op, word, a, b);
        exp_e = ref_edges(op, word, a, b);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.word_i  = word;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
        #1 check_eq("busy_accept", bus.busy_o, 1'b1);
        edges = 0;
        gap   = 0;
        do begin
            @(negedge clk);
            edges++;
            if (!bus.done_o && !bus.busy_o) gap = 1;
        end while (!bus.done_o && edges < 200);
        check_eq("latency", edges, exp_e);
        check_eq("busy_while_running", gap, 1'b0);
        check_eq("result", bus.result_o, exp);
        check_eq("busy_in_done", bus.busy_o, 1'b0);
        for (int i = 0; i < hold_cyc; i++) begin
            bus.hold_i = 1'b1;
            @(negedge clk);
            check_eq("hold_done", bus.done_o, 1'b1);
            check_eq("hold_result", bus.result_o, exp);
        end
        bus.hold_i = 1'b0;
        @(negedge clk);
        check_eq("idle_done", bus.done_o, 1'b0);
        check_eq("idle_result_kept", bus.result_o, exp);
        bus.valid_i = 1'b0;
    endtask

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = MinVal;
            3:       v = {$urandom, 32'h8000_0000};
            4:       v = 64'($urandom_range(0, 20));
            5:       v = {32'h0, $urandom};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        bus.valid_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.word_i  = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        bus.hold_i  = 1'b0;
        resetn      = 1'b0;
        repeat (2) @(negedge clk);
        bus.valid_i = 1'b1;
        #1;
        check_eq("reset_done", bus.done_o, 1'b0);
        check_eq("reset_result", bus.result_o, 64'd0);
        check_eq("reset_busy", bus.busy_o, 1'b0);
        bus.valid_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Directed cases
        run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op(3'd0, 1'b0, 64'd7, 64'd0, 0);
        run_op(3'd2, 1'b0, 64'd100, 64'd0, 0);
        run_op(3'd4, 1'b0, 64'd100, 64'd0, 0);
        run_op(3'd1, 1'b0, MinVal, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(3'd3, 1'b0, MinVal, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(3'd3, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 0);
        run_op(3'd1, 1'b0, 64'd100, 64'd7, 3);

        // Flush a DIVU at t+10, new op accepted at t+12
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = 3'd2;
        bus.word_i  = 1'b0;
        bus.a_i     = 64'd1000;
        bus.b_i     = 64'd3;
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        #1 check_eq("flush_busy", bus.busy_o, 1'b0);
        @(negedge clk);
        check_eq("flush_done", bus.done_o, 1'b0);
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        #1 check_eq("flush_idle_busy", bus.busy_o, 1'b0);
        run_op(3'd0, 1'b0, 64'd21, 64'd3, 0);

        // Reset mid-BUSY: previous result (63) must vanish immediately
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = 3'd1;
        bus.a_i     = 64'd5000;
        bus.b_i     = 64'd9;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq("midreset_busy", bus.busy_o, 1'b0);
        check_eq("midreset_done", bus.done_o, 1'b0);
        check_eq("midreset_result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.valid_i = 1'b0;
        resetn      = 1'b1;
        @(negedge clk);
        check_eq("postreset_done", bus.done_o, 1'b0);

        // Randomized ops against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  rop;
            logic        rword;
            logic [63:0] ra, rb;
            rop   = 3'($urandom_range(0, 7));
            rword = 1'($urandom_range(0, 1));
            ra    = pick_operand();
            rb    = pick_operand();
            run_op(rop, rword, ra, rb, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
